gemm_loop_seq: RTL and testbench

GEMM loop sequencer for the VTA GEMM core. Accepts one 128-bit GEMM instruction, walks the nested loops (outer iteration, inner iteration, micro-op range), fetches each micro-op from the micro-op buffer, and emits one beat per micro-op execution. Each beat carries the micro-op word, the current loop counters and the instruction's factor fields, which is exactly the input set of the index-decode stage it drives. It sits between instruction fetch and index decode.

---
 rtl/gemm_pkg.sv | 60 ++++++
 rtl/gemm_seq_fifo2.sv | 78 +++++++
 rtl/gemm_loop_seq.sv | 215 +++++++++++++++++++++
 tb/tb_gemm_loop_seq.sv | 275 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/gemm_pkg.sv
// ============================================================================
// Module : gemm_pkg
// Desc   : Shared constants and beat payload type for the GEMM loop sequencer.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

package gemm_pkg;

    localparam logic [2:0] OPC_GEMM = 3'd2;

    // 128-bit GEMM instruction field positions
    localparam int INSN_OPC_LSB  = 0;
    localparam int INSN_OPC_MSB  = 2;
    localparam int INSN_DEP_LSB  = 3;
    localparam int INSN_DEP_MSB  = 6;
    localparam int INSN_RST_BIT  = 7;
    localparam int INSN_BGN_LSB  = 8;
    localparam int INSN_BGN_MSB  = 20;
    localparam int INSN_END_LSB  = 21;
    localparam int INSN_END_MSB  = 34;
    localparam int INSN_IOUT_LSB = 35;
    localparam int INSN_IOUT_MSB = 48;
    localparam int INSN_IIN_LSB  = 49;
    localparam int INSN_IIN_MSB  = 62;
    localparam int INSN_DST_LSB  = 63;
    localparam int INSN_DST_MSB  = 84;
    localparam int INSN_SRC_LSB  = 85;
    localparam int INSN_SRC_MSB  = 106;
    localparam int INSN_WGT_LSB  = 107;
    localparam int INSN_WGT_MSB  = 126;

    // 32-bit micro-op field positions
    localparam int UOP_DST_LSB = 0;
    localparam int UOP_DST_MSB = 10;
    localparam int UOP_SRC_LSB = 11;
    localparam int UOP_SRC_MSB = 21;
    localparam int UOP_WGT_LSB = 22;
    localparam int UOP_WGT_MSB = 31;

    typedef struct packed {
        logic [31:0] uop;
        logic [13:0] iter_out;
        logic [13:0] iter_in;
        logic [21:0] dst_factor;
        logic [21:0] src_factor;
        logic [19:0] wgt_factor;
        logic        reset_reg;
        logic        last;
    } beat_t;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_RUN   = 2'd1,
        S_DRAIN = 2'd2
    } seq_state_e;

endpackage

`default_nettype wire

// File: rtl/gemm_seq_fifo2.sv
// ============================================================================
// Module : gemm_seq_fifo2
// Desc   : Two-entry FIFO for beat payloads; head register drives the output.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module gemm_seq_fifo2
    import gemm_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        push_i,
    input  beat_t       push_data_i,
    input  logic        ready_i,
    output logic        valid_o,
    output logic        pop_o,
    output beat_t       data_o,
    output logic [1:0]  count_o
);

    beat_t      head_q, head_d;
    beat_t      tail_q, tail_d;
    logic [1:0] count_q, count_d;
    logic       w_pop;

    assign w_pop   = ready_i & (count_q != 2'd0);
    assign valid_o = (count_q != 2'd0);
    assign pop_o   = w_pop;
    assign data_o  = head_q;
    assign count_o = count_q;

    // Upstream credit guarantees push never arrives while full without a pop.
    always_comb begin
        head_d  = head_q;
        tail_d  = tail_q;
        count_d = count_q;
        case ({push_i, w_pop})
            2'b10: begin
                if (count_q == 2'd0) begin
                    head_d  = push_data_i;
                    count_d = 2'd1;
                end else if (count_q == 2'd1) begin
                    tail_d  = push_data_i;
                    count_d = 2'd2;
                end
            end
            2'b01: begin
                if (count_q == 2'd2) head_d = tail_q;
                count_d = count_q - 2'd1;
            end
            2'b11: begin
                if (count_q == 2'd1) begin
                    head_d = push_data_i;
                end else begin
                    head_d = tail_q;
                    tail_d = push_data_i;
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= 2'd0;
        end else begin
            head_q  <= head_d;
            tail_q  <= tail_d;
            count_q <= count_d;
        end
    end

endmodule

`default_nettype wire

// File: rtl/gemm_loop_seq.sv
// ============================================================================
// Module : gemm_loop_seq
// Desc   : GEMM loop sequencer: walks outer/inner/uop loops, emits one beat per
//          micro-op. Optional beat counter enabled by macro GEMM_SEQ_PERF_EN.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module gemm_loop_seq
    import gemm_pkg::*;
#(
    parameter int UOP_AW = 13
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [127:0]      insn,
    input  logic              insn_valid,
    output logic              insn_ready,
    output logic              uop_rd_en,
    output logic [UOP_AW-1:0] uop_rd_addr,
    input  logic [31:0]       uop_rd_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [31:0]       out_uop,
    output logic [13:0]       out_iter_out,
    output logic [13:0]       out_iter_in,
    output logic [21:0]       out_dst_factor,
    output logic [21:0]       out_src_factor,
    output logic [19:0]       out_wgt_factor,
    output logic              out_reset_reg,
    output logic              out_last,
    output logic              done
`ifdef GEMM_SEQ_PERF_EN
    ,
    output logic [31:0]       perf_beats
`endif
);

    seq_state_e  state_q, state_d;
    logic [13:0] n_out_q, n_in_q, bgn_q, end_q;
    logic [21:0] dst_q, src_q;
    logic [19:0] wgt_q;
    logic        rr_q, degen_q;
    logic [13:0] cur_out_q, cur_out_d, cur_in_q, cur_in_d, addr_q, addr_d;
    logic        inflight_q;
    logic [13:0] meta_out_q, meta_in_q;
    logic        meta_last_q;
    logic        done_q, done_d;

    logic [13:0] w_bgn, w_end, w_nout, w_nin;
    logic        w_degen, w_accept, w_pop, w_fifo_valid, w_credit, w_final, w_drained;
    logic        w_last_addr, w_last_in, w_last_out, w_unused_bits;
    logic [1:0]  w_fifo_count;
    beat_t       w_push_data, w_head;

    assign w_bgn  = {1'b0, insn[INSN_BGN_MSB:INSN_BGN_LSB]};
    assign w_end  = insn[INSN_END_MSB:INSN_END_LSB];
    assign w_nout = insn[INSN_IOUT_MSB:INSN_IOUT_LSB];
    assign w_nin  = insn[INSN_IIN_MSB:INSN_IIN_LSB];
    assign w_degen = (w_nout == 14'd0) || (w_nin == 14'd0) || (w_end <= w_bgn) ||
                     (insn[INSN_OPC_MSB:INSN_OPC_LSB] != OPC_GEMM);
    assign w_unused_bits = ^{insn[INSN_DEP_MSB:INSN_DEP_LSB], insn[127]};

    assign insn_ready  = (state_q == S_IDLE) && !rst;
    assign w_accept    = insn_valid && insn_ready;
    assign w_last_addr = ((addr_q + 14'd1) == end_q);
    assign w_last_in   = (cur_in_q == (n_in_q - 14'd1));
    assign w_last_out  = (cur_out_q == (n_out_q - 14'd1));
    assign w_final     = w_last_addr && w_last_in && w_last_out;
    // A beat leaving this cycle frees its slot, which sustains one beat per cycle.
    assign w_credit    = ({1'b0, w_fifo_count} + {2'b00, inflight_q}) < (3'd2 + {2'b00, w_pop});
    assign w_drained   = !inflight_q && ((w_fifo_count == 2'd0) || ((w_fifo_count == 2'd1) && w_pop));
    assign uop_rd_addr = UOP_AW'(addr_q);
    assign done        = done_q;

    always_comb begin
        state_d   = state_q;
        cur_out_d = cur_out_q;
        cur_in_d  = cur_in_q;
        addr_d    = addr_q;
        uop_rd_en = 1'b0;
        done_d    = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (w_accept) begin
                    cur_out_d = 14'd0;
                    cur_in_d  = 14'd0;
                    addr_d    = w_bgn;
                    state_d   = w_degen ? S_DRAIN : S_RUN;
                    done_d    = w_degen;
                end
            end
            S_RUN: begin
                if (w_credit && !rst) begin
                    uop_rd_en = 1'b1;
                    if (w_final) begin
                        state_d = S_DRAIN;
                    end else if (w_last_addr) begin
                        addr_d = bgn_q;
                        if (w_last_in) begin
                            cur_in_d  = 14'd0;
                            cur_out_d = cur_out_q + 14'd1;
                        end else begin
                            cur_in_d = cur_in_q + 14'd1;
                        end
                    end else begin
                        addr_d = addr_q + 14'd1;
                    end
                end
            end
            S_DRAIN: begin
                if (w_drained) begin
                    state_d = S_IDLE;
                    done_d  = !degen_q;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= S_IDLE;
            n_out_q     <= '0;
            n_in_q      <= '0;
            bgn_q       <= '0;
            end_q       <= '0;
            dst_q       <= '0;
            src_q       <= '0;
            wgt_q       <= '0;
            rr_q        <= 1'b0;
            degen_q     <= 1'b0;
            cur_out_q   <= '0;
            cur_in_q    <= '0;
            addr_q      <= '0;
            inflight_q  <= 1'b0;
            meta_out_q  <= '0;
            meta_in_q   <= '0;
            meta_last_q <= 1'b0;
            done_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            cur_out_q  <= cur_out_d;
            cur_in_q   <= cur_in_d;
            addr_q     <= addr_d;
            inflight_q <= uop_rd_en;
            done_q     <= done_d;
            if (uop_rd_en) begin
                meta_out_q  <= cur_out_q;
                meta_in_q   <= cur_in_q;
                meta_last_q <= w_final;
            end
            if (w_accept) begin
                n_out_q <= w_nout;
                n_in_q  <= w_nin;
                bgn_q   <= w_bgn;
                end_q   <= w_end;
                dst_q   <= insn[INSN_DST_MSB:INSN_DST_LSB];
                src_q   <= insn[INSN_SRC_MSB:INSN_SRC_LSB];
                wgt_q   <= insn[INSN_WGT_MSB:INSN_WGT_LSB];
                rr_q    <= insn[INSN_RST_BIT];
                degen_q <= w_degen;
            end
        end
    end

    always_comb begin
        w_push_data            = '0;
        w_push_data.uop        = uop_rd_data;
        w_push_data.iter_out   = meta_out_q;
        w_push_data.iter_in    = meta_in_q;
        w_push_data.dst_factor = dst_q;
        w_push_data.src_factor = src_q;
        w_push_data.wgt_factor = wgt_q;
        w_push_data.reset_reg  = rr_q;
        w_push_data.last       = meta_last_q;
    end

    gemm_seq_fifo2 u_fifo (
        .clk         (clk),
        .rst         (rst),
        .push_i      (inflight_q),
        .push_data_i (w_push_data),
        .ready_i     (out_ready),
        .valid_o     (w_fifo_valid),
        .pop_o       (w_pop),
        .data_o      (w_head),
        .count_o     (w_fifo_count)
    );

    assign out_valid      = w_fifo_valid;
    assign out_uop        = w_head.uop;
    assign out_iter_out   = w_head.iter_out;
    assign out_iter_in    = w_head.iter_in;
    assign out_dst_factor = w_head.dst_factor;
    assign out_src_factor = w_head.src_factor;
    assign out_wgt_factor = w_head.wgt_factor;
    assign out_reset_reg  = w_head.reset_reg;
    assign out_last       = w_head.last;

`ifdef GEMM_SEQ_PERF_EN
    logic [31:0] perf_q;
    always_ff @(posedge clk) begin
        if (rst) begin
            perf_q <= '0;
        end else if (w_pop && (perf_q != '1)) begin
            perf_q <= perf_q + 32'd1;
        end
    end
    assign perf_beats = perf_q;
`endif

endmodule

`default_nettype wire

// File: tb/tb_gemm_loop_seq.sv
// ============================================================================
// Module : tb_gemm_loop_seq
// Desc   : Scoreboard bench for gemm_loop_seq with directed instructions.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_gemm_loop_seq;
    import gemm_pkg::*;

    localparam int UOP_AW = 13;

    logic              clk, rst;
    logic [127:0]      insn;
    logic              insn_valid, insn_ready;
    logic              uop_rd_en;
    logic [UOP_AW-1:0] uop_rd_addr;
    logic [31:0]       uop_rd_data;
    logic              out_valid, out_ready;
    logic [31:0]       out_uop;
    logic [13:0]       out_iter_out, out_iter_in;
    logic [21:0]       out_dst_factor, out_src_factor;
    logic [19:0]       out_wgt_factor;
    logic              out_reset_reg, out_last, done;
`ifdef GEMM_SEQ_PERF_EN
    logic [31:0]       perf_beats;
`endif

    gemm_loop_seq #(.UOP_AW(UOP_AW)) dut (
        .clk(clk), .rst(rst), .insn(insn), .insn_valid(insn_valid), .insn_ready(insn_ready),
        .uop_rd_en(uop_rd_en), .uop_rd_addr(uop_rd_addr), .uop_rd_data(uop_rd_data),
        .out_valid(out_valid), .out_ready(out_ready), .out_uop(out_uop),
        .out_iter_out(out_iter_out), .out_iter_in(out_iter_in),
        .out_dst_factor(out_dst_factor), .out_src_factor(out_src_factor),
        .out_wgt_factor(out_wgt_factor), .out_reset_reg(out_reset_reg),
        .out_last(out_last), .done(done)
`ifdef GEMM_SEQ_PERF_EN
        , .perf_beats(perf_beats)
`endif
    );

    int    n_cmp = 0, n_fail = 0, cyc = 0;
    int    first_rd, first_valid, last_hs, beats, rd_cnt, done_cnt;
    int    rd_total = 0, beat_total = 0;
    bit    toggle_mode = 0;
    beat_t sb[$];

    initial begin clk = 1'b0; forever #5 clk = ~clk; end
    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [31:0] uop_word(input logic [12:0] a);
        return {8'hA5, 11'h000, a};
    endfunction

    // Micro-op buffer: one-cycle read latency, garbage when not read.
    always @(posedge clk) uop_rd_data <= uop_rd_en ? uop_word(uop_rd_addr) : 32'hDEAD_BEEF;

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic logic [127:0] mk_insn(input logic [2:0] opc, input logic rr,
            input logic [12:0] bgn, input logic [13:0] en, input logic [13:0] nout,
            input logic [13:0] nin, input logic [21:0] dst, input logic [21:0] src,
            input logic [19:0] wgt);
        logic [127:0] r;
        r = '0;
        r[2:0] = opc;     r[7] = rr;        r[20:8] = bgn;    r[34:21] = en;
        r[48:35] = nout;  r[62:49] = nin;   r[84:63] = dst;   r[106:85] = src;
        r[126:107] = wgt;
        return r;
    endfunction

    task automatic push_expected(input logic [127:0] ins);
        int nout, nin, bg, en;
        beat_t b;
        nout = int'(ins[48:35]); nin = int'(ins[62:49]);
        bg = int'(ins[20:8]);    en = int'(ins[34:21]);
        if (ins[2:0] != 3'd2 || nout == 0 || nin == 0 || en <= bg) return;
        for (int o = 0; o < nout; o++)
            for (int i = 0; i < nin; i++)
                for (int a = bg; a < en; a++) begin
                    b.uop        = uop_word(13'(a));
                    b.iter_out   = 14'(o);
                    b.iter_in    = 14'(i);
                    b.dst_factor = ins[84:63];
                    b.src_factor = ins[106:85];
                    b.wgt_factor = ins[126:107];
                    b.reset_reg  = ins[7];
                    b.last       = (o == nout-1) && (i == nin-1) && (a == en-1);
                    sb.push_back(b);
                end
    endtask

    // out_ready driver: held high, or the 1,0,0,1 pattern when toggling
    initial begin
        logic [3:0] pat;
        int ph;
        pat = 4'b1001; ph = 0; out_ready = 1'b1;
        forever begin
            @(posedge clk); #1;
            if (toggle_mode) begin out_ready = pat[ph]; ph = (ph + 1) % 4; end
            else out_ready = 1'b1;
        end
    end

    // Monitor: pops the scoreboard on every beat handshake
    initial begin
        beat_t cur, hold, exp;
        bit hold_v;
        hold_v = 0; hold = '0;
        forever begin
            @(negedge clk);
            if (rst) begin
                hold_v = 0; rd_total = 0; beat_total = 0;
            end else begin
                cur = {out_uop, out_iter_out, out_iter_in, out_dst_factor,
                       out_src_factor, out_wgt_factor, out_reset_reg, out_last};
                if (hold_v) chk("stall_stable", cur, hold);
                if (uop_rd_en) begin
                    rd_cnt++; rd_total++;
                    if (first_rd < 0) first_rd = cyc;
                end
                if (out_valid && first_valid < 0) first_valid = cyc;
                if (out_valid && out_ready) begin
                    beats++; beat_total++;
                    if (out_last) last_hs = cyc;
                    if (sb.size() == 0) begin
                        n_cmp++; n_fail++;
                        $display("FAIL unexpected_beat: got %0h expected none", cur);
                    end else begin
                        exp = sb.pop_front();
                        chk("beat", cur, exp);
                    end
                end
                if (uop_rd_en) chk("outstanding_le2", 128'(rd_total - beat_total <= 2), 128'd1);
                hold_v = out_valid && !out_ready;
                hold = cur;
                if (done) done_cnt++;
            end
        end
    end

    task automatic run_insn(input logic [127:0] ins, output int t_acc);
        push_expected(ins);
        first_rd = -1; first_valid = -1; last_hs = -1;
        beats = 0; rd_cnt = 0; done_cnt = 0; t_acc = -1;
        @(posedge clk); #1;
        insn = ins; insn_valid = 1'b1;
        for (int k = 0; k < 20; k++) begin
            @(negedge clk);
            if (insn_ready) begin t_acc = cyc; break; end
        end
        @(posedge clk); #1;
        insn_valid = 1'b0; insn = '0;
        if (t_acc < 0) chk("accept_timeout", 128'd0, 128'd1);
    endtask

    task automatic wait_done(input bit check_ready, output int dc);
        dc = -1;
        for (int k = 0; k < 400; k++) begin
            @(negedge clk);
            if (done) begin
                dc = cyc;
                if (check_ready) chk("ready_at_done", 128'(insn_ready), 128'd1);
                break;
            end
        end
        if (dc < 0) chk("done_timeout", 128'd0, 128'd1);
        repeat (3) @(negedge clk);
    endtask

    task automatic run_degen(input string nm, input logic [127:0] ins);
        int t, dc;
        run_insn(ins, t);
        wait_done(0, dc);
        chk({nm, "_done_t1"}, 128'(dc - t), 128'd1);
        chk({nm, "_no_reads"}, 128'(rd_cnt), 128'd0);
        chk({nm, "_no_beats"}, 128'(beats), 128'd0);
        chk({nm, "_one_done"}, 128'(done_cnt), 128'd1);
    endtask

    initial begin
        #300000;
        $display("FAIL watchdog: got timeout required finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [127:0] ins_a, ins_f;
        int t, dc;
        insn = '0; insn_valid = 1'b1; rst = 1'b1;
        first_rd = -1; first_valid = -1; last_hs = -1; beats = 0; rd_cnt = 0; done_cnt = 0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_insn_ready", 128'(insn_ready), 128'd0);
        chk("rst_out_valid", 128'(out_valid), 128'd0);
        chk("rst_rd_en", 128'(uop_rd_en), 128'd0);
        chk("rst_rd_addr", 128'(uop_rd_addr), 128'd0);
        chk("rst_done", 128'(done), 128'd0);
        chk("rst_data", {out_uop, out_iter_out, out_iter_in, out_last}, 128'd0);
        insn_valid = 1'b0;
        @(posedge clk); #1 rst = 1'b0;

        // 2 x 3 x uop 4..5, full throughput
        ins_a = mk_insn(3'd2, 1'b0, 13'd4, 14'd6, 14'd2, 14'd3, 22'h012345, 22'h0ABCDE, 20'h13579);
        run_insn(ins_a, t);
        wait_done(1, dc);
        chk("A_first_rd", 128'(first_rd - t), 128'd1);
        chk("A_first_valid", 128'(first_valid - t), 128'd3);
        chk("A_beats", 128'(beats), 128'd12);
        chk("A_reads", 128'(rd_cnt), 128'd12);
        chk("A_back_to_back", 128'(last_hs - first_valid), 128'd11);
        chk("A_done_after_last", 128'(dc - last_hs), 128'd1);
        chk("A_one_done", 128'(done_cnt), 128'd1);
        chk("A_sb_empty", 128'(sb.size()), 128'd0);

        // factor fields and reset_reg propagate to every beat
        ins_f = mk_insn(3'd2, 1'b1, 13'd0, 14'd3, 14'd1, 14'd2, 22'h2AAAA7, 22'h15555A, 20'hABCDE);
        run_insn(ins_f, t);
        wait_done(1, dc);
        chk("F_beats", 128'(beats), 128'd6);
        chk("F_sb_empty", 128'(sb.size()), 128'd0);
`ifdef GEMM_SEQ_PERF_EN
        chk("perf_beats_18", 128'(perf_beats), 128'd18);
`endif

        run_degen("nin0", mk_insn(3'd2, 1'b0, 13'd4, 14'd6, 14'd2, 14'd0, 22'h1, 22'h2, 20'h3));
        run_degen("empty_range", mk_insn(3'd2, 1'b0, 13'd5, 14'd5, 14'd2, 14'd3, 22'h1, 22'h2, 20'h3));
        run_degen("opc0", mk_insn(3'd0, 1'b0, 13'd4, 14'd6, 14'd2, 14'd3, 22'h1, 22'h2, 20'h3));

        // backpressure 1,0,0,1
        toggle_mode = 1;
        run_insn(ins_a, t);
        wait_done(1, dc);
        toggle_mode = 0;
        chk("T_beats", 128'(beats), 128'd12);
        chk("T_done_after_last", 128'(dc - last_hs), 128'd1);
        chk("T_sb_empty", 128'(sb.size()), 128'd0);

        // abort mid-instruction
        run_insn(ins_a, t);
        for (int k = 0; k < 100; k++) begin
            @(posedge clk); #2;
            if (beats >= 3) break;
        end
        chk("abort_read_in_flight", 128'(uop_rd_en), 128'd1);
        rst = 1'b1;
        @(posedge clk); #1;
        sb.delete();
        @(negedge clk);
        chk("abort_out_valid", 128'(out_valid), 128'd0);
        chk("abort_done", 128'(done), 128'd0);
        @(posedge clk); #1 rst = 1'b0;
        repeat (5) @(negedge clk);
        chk("abort_no_done", 128'(done_cnt), 128'd0);
        chk("abort_idle_ready", 128'(insn_ready), 128'd1);

        run_insn(mk_insn(3'd2, 1'b0, 13'd7, 14'd8, 14'd1, 14'd1, 22'h3, 22'h4, 20'h5), t);
        wait_done(1, dc);
        chk("single_beats", 128'(beats), 128'd1);
        chk("single_done", 128'(done_cnt), 128'd1);
        chk("single_sb_empty", 128'(sb.size()), 128'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule

`default_nettype wire
